// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared constants for the clock divider bank: system clock
//                rate, standard channel frequencies and a helper that turns a
//                target frequency into a divider half-period.
//  Revision    : 1.0  initial release
// ============================================================================
package clk_div_pkg;

  localparam int unsigned SYS_CLK_HZ = 100_000_000;

  // Standard channel frequencies used on the CPU board
  localparam int unsigned c_freq_slow_hz     = 1;       // slow-step clock
  localparam int unsigned c_freq_scan_hz     = 1_000;   // seven-segment scan
  localparam int unsigned c_freq_debounce_hz = 100;     // debounce sampling

  // Half-period in system clocks for a 50% duty output at freq_hz
  function automatic int unsigned half_period(input int unsigned freq_hz);
    return SYS_CLK_HZ / (2 * freq_hz);
  endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_chan
//  Description : One divider channel. Counts 0..H-1 and toggles clk_out at the
//                terminal count; tick marks each 0->1 edge. A shadow
//                half-period is promoted to active only at a full-period
//                boundary, while stopped, or on restart, so a period never
//                mixes two different H values.
//                Optional macro CLKDIV_READBACK_EN exposes the active
//                half-period and the pending flag.
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               CNT_W      = 32,
  parameter logic [CNT_W-1:0] RESET_HALF = CNT_W'(half_period(c_freq_slow_hz))
) (
  input  logic             clk,
  input  logic             reset,     // synchronous, active-low
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
  output logic             clk_out,
  output logic             tick
`ifdef CLKDIV_READBACK_EN
  ,
  output logic [CNT_W-1:0] active_half,
  output logic             pending
`endif
);

  logic [CNT_W-1:0] count_q,  count_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q,    tick_d;

  logic w_running;
  logic w_terminal;
  logic w_xfer;

  // H=0 behaves exactly like a disabled channel
  assign w_running  = en && (active_q != '0);
  assign w_terminal = (count_q == active_q - CNT_W'(1));
  // Shadow may be promoted: restart, stopped, or end of the high half
  assign w_xfer     = restart || !w_running || (w_terminal && clk_out_q);

  // Next-state: counter/toggle/tick and shadow-to-active promotion
  always_comb begin
    count_d   = count_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    if (restart || !w_running) begin
      count_d   = '0;
      clk_out_d = 1'b0;
    end else if (w_terminal) begin
      count_d   = '0;
      clk_out_d = ~clk_out_q;
      tick_d    = ~clk_out_q;    // only on the low-to-high toggle
    end else begin
      count_d   = count_q + CNT_W'(1);
    end

    if (wr) begin
      shadow_d  = wr_half;
      pending_d = 1'b1;
    end

    // Fresh write data wins over an older pending shadow
    if (w_xfer) begin
      if (wr) begin
        active_d = wr_half;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q   <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      active_q  <= RESET_HALF;
      shadow_q  <= RESET_HALF;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

`ifdef CLKDIV_READBACK_EN
  assign active_half = active_q;
  assign pending     = pending_q;
`endif

endmodule : clk_div_chan
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_bank
//  Description : NUM_CH independent 50% duty clock dividers with per-channel
//                tick strobes, runtime-programmable half-periods and a global
//                phase-aligning restart.
//                Optional macro CLKDIV_READBACK_EN adds rd_ch / rd_half /
//                rd_pending readback of a channel's active half-period.
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = half_period(c_freq_slow_hz)
) (
  input  logic              clk,
  input  logic              reset,         // synchronous, active-low
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [CNT_W-1:0]  wr_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
`ifdef CLKDIV_READBACK_EN
  ,
  input  logic [3:0]        rd_ch,
  output logic [CNT_W-1:0]  rd_half,
  output logic              rd_pending
`endif
);

  localparam logic [CNT_W-1:0] c_reset_half = CNT_W'(DEFAULT_HALF);

`ifdef CLKDIV_READBACK_EN
  logic [CNT_W-1:0]  w_active [NUM_CH];
  logic [NUM_CH-1:0] w_pending;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range wr_ch never matches any channel, so it is dropped
    logic w_wr_sel;
    assign w_wr_sel = wr_en && (wr_ch == 4'(i));

    clk_div_chan #(
      .CNT_W      (CNT_W),
      .RESET_HALF (c_reset_half)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .en          (ch_en[i]),
      .restart     (sync_restart),
      .wr          (w_wr_sel),
      .wr_half     (wr_half),
      .clk_out     (clk_out[i]),
      .tick        (tick[i])
`ifdef CLKDIV_READBACK_EN
      ,
      .active_half (w_active[i]),
      .pending     (w_pending[i])
`endif
    );
  end : g_ch

`ifdef CLKDIV_READBACK_EN
  // Readback mux; unused channel indices read as zero
  always_comb begin
    rd_half    = '0;
    rd_pending = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (rd_ch == 4'(j)) begin
        rd_half    = w_active[j];
        rd_pending = w_pending[j];
      end
    end
  end
`endif

endmodule : clk_div_bank
`default_nettype wire
